spi_slave_shifter: RTL and testbench

//  SPI responder (slave) datapath, the counterpart of the master-side SCLK/baud generator.

---
 rtl/spi_slave_shifter_if.sv | 40 ++++
 rtl/spi_slave_shifter.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_spi_slave_shifter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_shifter_if.sv
// Register-file side of the SPI responder: TX holding-buffer write port,
// RX data/flags and transfer status.
interface spi_slave_shifter_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ack;
  logic              rx_overrun;
  logic              busy;

  // Register file / consumer side
  modport master (
    output tx_data,
    output tx_valid,
    output rx_ack,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_overrun,
    input  busy
  );

  // Shifter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    input  rx_ack,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output rx_overrun,
    output busy
  );

endinterface

// File: rtl/spi_slave_shifter.sv
// SPI responder datapath. Oversamples SCLK/SS_n/MOSI in the PCLK domain,
// recovers sample/shift strobes from CPOL/CPHA and shifts one DATA_W-bit
// word in on MOSI and out on MISO per word time.
// Optional feature macro: SPI_SLAVE_LSBFE_EN adds the lsbfe port
// (1 = LSB first on both lines); without it words are always MSB first.
module spi_slave_shifter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic spi_en,
  input  logic cpol,
  input  logic cpha,
`ifdef SPI_SLAVE_LSBFE_EN
  input  logic lsbfe,
`endif
  input  logic sclk_in,
  input  logic ss_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  spi_slave_shifter_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Bit order select
  logic lsb_first;
`ifdef SPI_SLAVE_LSBFE_EN
  assign lsb_first = lsbfe;
`else
  assign lsb_first = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_d;
  logic                   ss_d;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ss_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Synchroniser chains plus one-cycle delayed copies for edge detection
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_in};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sclk_d <= sclk_s;
      ss_d   <= ss_s;
    end
  end

  logic sclk_rise_c;
  logic sclk_fall_c;
  logic lead_c;
  logic trail_c;
  logic sample_c;
  logic shift_c;
  logic ss_fall_c;
  logic abort_c;

  // Map raw SCLK edges onto leading/trailing, then onto sample/shift by CPHA
  always_comb begin
    sclk_rise_c = sclk_s & ~sclk_d;
    sclk_fall_c = ~sclk_s & sclk_d;
    lead_c      = cpol ? sclk_fall_c : sclk_rise_c;
    trail_c     = cpol ? sclk_rise_c : sclk_fall_c;
    sample_c    = cpha ? trail_c : lead_c;
    shift_c     = cpha ? lead_c : trail_c;
    ss_fall_c   = ~ss_s & ss_d;
    abort_c     = ss_s | ~spi_en;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic             load_c;
  logic             stop_c;
  logic             sample_en_c;
  logic             shift_en_c;
  logic             word_done_c;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_nxt   = state;
    load_c      = 1'b0;
    stop_c      = 1'b0;
    sample_en_c = 1'b0;
    shift_en_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (spi_en && ss_fall_c) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_c) begin
          state_nxt = S_IDLE;
          stop_c    = 1'b1;
        end else begin
          state_nxt = S_XFER;
          load_c    = 1'b1;
        end
      end
      S_XFER: begin
        if (abort_c) begin
          state_nxt = S_IDLE;
          stop_c    = 1'b1;
        end else begin
          sample_en_c = sample_c;
          shift_en_c  = shift_c;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    word_done_c = sample_en_c && (bit_cnt == LAST_BIT);
  end

  // ---------------------------------------------------------------------------
  // TX holding buffer
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_buf;
  logic              buf_full;
  logic              buf_full_nxt;
  logic              tx_ready_q;
  logic              tx_wr_c;
  logic              tx_take_c;
  logic [DATA_W-1:0] buf_word_c;

  // A take always sees the buffer contents from before any same-cycle write
  always_comb begin
    tx_wr_c      = bus.tx_valid & tx_ready_q;
    tx_take_c    = load_c | word_done_c;
    buf_word_c   = buf_full ? tx_buf : '0;
    buf_full_nxt = buf_full;
    if (tx_take_c) begin
      buf_full_nxt = 1'b0;
    end
    if (tx_wr_c) begin
      buf_full_nxt = 1'b1;
    end
  end

  // Holding buffer storage and ready flag
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_buf     <= '0;
      buf_full   <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      if (tx_wr_c) begin
        tx_buf <= bus.tx_data;
      end
      buf_full   <= buf_full_nxt;
      tx_ready_q <= ~buf_full_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-order helpers
  // ---------------------------------------------------------------------------
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // ---------------------------------------------------------------------------
  // TX shifter / MISO
  // ---------------------------------------------------------------------------
  // tx_sh holds the bits not yet driven onto MISO. With cpha=0 the first bit
  // goes out at LOAD, so the register is pre-advanced; with cpha=1 the first
  // leading edge drives it again, so the word is loaded unshifted.
  logic [DATA_W-1:0] tx_sh;
  logic              miso_q;
  logic              miso_oe_q;

  // MISO drive, output enable and transmit shift register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_sh     <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
    end else if (load_c) begin
      miso_oe_q <= 1'b1;
      miso_q    <= first_bit(buf_word_c, lsb_first);
      tx_sh     <= cpha ? buf_word_c : advance(buf_word_c, lsb_first);
    end else if (state_nxt != S_XFER) begin
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      if (shift_en_c) begin
        miso_q <= first_bit(tx_sh, lsb_first);
        tx_sh  <= advance(tx_sh, lsb_first);
      end
      if (word_done_c) begin
        tx_sh <= buf_word_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX shifter, bit counter and RX flags
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_word_c;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_overrun_q;
  logic              busy_q;

  // Receive word as it stands after inserting the current MOSI sample
  always_comb begin
    if (lsb_first) begin
      rx_word_c = {mosi_s, rx_sh[DATA_W-1:1]};
    end else begin
      rx_word_c = {rx_sh[DATA_W-2:0], mosi_s};
    end
  end

  // Receive shift register and bit counter; aborts discard the partial word
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else if (load_c || stop_c) begin
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else if (sample_en_c) begin
      rx_sh   <= rx_word_c;
      bit_cnt <= word_done_c ? '0 : (bit_cnt + CNT_W'(1));
    end
  end

  // Completed-word hand-off: an ack in the completion cycle frees the slot
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else if (word_done_c) begin
      if (!rx_valid_q || bus.rx_ack) begin
        rx_data_q    <= rx_word_c;
        rx_valid_q   <= 1'b1;
        rx_overrun_q <= 1'b0;
      end else begin
        rx_overrun_q <= 1'b1;
      end
    end else if (bus.rx_ack) begin
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end
  end

  // Registered busy flag tracks the XFER state
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == S_XFER);
    end
  end

  assign miso           = miso_q;
  assign miso_oe        = miso_oe_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_overrun = rx_overrun_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a bit-banged SPI master drives the
// pins while the bench acts as the register file on the interface.
`timescale 1ns/1ps
module tb_spi_slave_shifter;

  localparam int unsigned DATA_W = 8;
  localparam int HALF = 6;

  logic PCLK = 1'b0;
  logic PRESETn;
  logic spi_en;
  logic cpol;
  logic cpha;
  logic sclk_in;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;
`ifdef SPI_SLAVE_LSBFE_EN
  logic lsbfe;
`endif

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] mrx;

  spi_slave_shifter_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_shifter #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .spi_en  (spi_en),
    .cpol    (cpol),
    .cpha    (cpha),
`ifdef SPI_SLAVE_LSBFE_EN
    .lsbfe   (lsbfe),
`endif
    .sclk_in (sclk_in),
    .ss_n    (ss_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    clks(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic rx_ack_pulse();
    bus.rx_ack = 1'b1;
    clks(1);
    bus.rx_ack = 1'b0;
    clks(1);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol    = p;
    cpha    = h;
    sclk_in = p;
    clks(8);
  endtask

  task automatic sel();
    ss_n = 1'b0;
    clks(8);
  endtask

  task automatic desel();
    clks(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    clks(8);
  endtask

  // Master side of one word (or nbits of it); returns what it saw on MISO
  task automatic spi_word(input logic [7:0] mtx, input int nbits, input bit lsbf,
                          output logic [7:0] rx);
    logic b;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      b = lsbf ? mtx[i] : mtx[7-i];
      if (!cpha) begin
        mosi = b;
        clks(HALF);
        rx = lsbf ? {miso, rx[7:1]} : {rx[6:0], miso};
        sclk_in = ~cpol;
        clks(HALF);
        sclk_in = cpol;
      end else begin
        sclk_in = ~cpol;
        mosi    = b;
        clks(HALF);
        rx = lsbf ? {miso, rx[7:1]} : {rx[6:0], miso};
        sclk_in = cpol;
        clks(HALF);
      end
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_miso"},       32'(miso),           32'h0);
    chk({pfx, "_miso_oe"},    32'(miso_oe),        32'h0);
    chk({pfx, "_tx_ready"},   32'(bus.tx_ready),   32'h1);
    chk({pfx, "_rx_data"},    32'(bus.rx_data),    32'h0);
    chk({pfx, "_rx_valid"},   32'(bus.rx_valid),   32'h0);
    chk({pfx, "_rx_overrun"}, 32'(bus.rx_overrun), 32'h0);
    chk({pfx, "_busy"},       32'(bus.busy),       32'h0);
  endtask

  initial begin
    PRESETn      = 1'b0;
    spi_en       = 1'b1;
    cpol         = 1'b0;
    cpha         = 1'b0;
    sclk_in      = 1'b0;
    ss_n         = 1'b1;
    mosi         = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ack   = 1'b0;
`ifdef SPI_SLAVE_LSBFE_EN
    lsbfe        = 1'b0;
`endif
    clks(3);
    chk_reset_values("rst");
    PRESETn = 1'b1;
    clks(4);

    // Mode 0: slave 0xA5 preloaded, master sends 0x3C
    tx_write(8'hA5);
    chk("t1_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    sel();
    chk("t1_miso_oe",       32'(miso_oe),      32'h1);
    chk("t1_busy",          32'(bus.busy),     32'h1);
    chk("t1_tx_ready_load", 32'(bus.tx_ready), 32'h1);
    chk("t1_miso_first",    32'(miso),         32'h1);
    spi_word(8'h3C, 8, 1'b0, mrx);
    desel();
    chk("t1_rx_data",  32'(bus.rx_data),    32'h3C);
    chk("t1_rx_valid", 32'(bus.rx_valid),   32'h1);
    chk("t1_miso_seq", 32'(mrx),            32'hA5);
    chk("t1_overrun",  32'(bus.rx_overrun), 32'h0);
    chk("t1_oe_off",   32'(miso_oe),        32'h0);
    chk("t1_idle",     32'(bus.busy),       32'h0);
    rx_ack_pulse();
    chk("t1_ack_valid", 32'(bus.rx_valid), 32'h0);

    // Modes 1..3: master 0xC3, slave 0x5A
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_write(8'h5A);
      sel();
      spi_word(8'hC3, 8, 1'b0, mrx);
      desel();
      chk($sformatf("t2_m%0d_rx_data", m),  32'(bus.rx_data),  32'hC3);
      chk($sformatf("t2_m%0d_rx_valid", m), 32'(bus.rx_valid), 32'h1);
      chk($sformatf("t2_m%0d_miso", m),     32'(mrx),          32'h5A);
      rx_ack_pulse();
    end
    set_mode(1'b0, 1'b0);

    // Back-to-back words without ack: first word kept, overrun flagged
    tx_write(8'h96);
    sel();
    chk("t3_tx_ready_load", 32'(bus.tx_ready), 32'h1);
    tx_write(8'h69);
    chk("t3_tx_ready_full", 32'(bus.tx_ready), 32'h0);
    spi_word(8'h11, 8, 1'b0, mrx);
    chk("t3_miso_w1", 32'(mrx), 32'h96);
    spi_word(8'h22, 8, 1'b0, mrx);
    chk("t3_miso_w2", 32'(mrx), 32'h69);
    desel();
    chk("t3_rx_data",  32'(bus.rx_data),    32'h11);
    chk("t3_rx_valid", 32'(bus.rx_valid),   32'h1);
    chk("t3_overrun",  32'(bus.rx_overrun), 32'h1);
    chk("t3_tx_ready", 32'(bus.tx_ready),   32'h1);
    rx_ack_pulse();
    chk("t3_ack_valid",   32'(bus.rx_valid),   32'h0);
    chk("t3_ack_overrun", 32'(bus.rx_overrun), 32'h0);

    // Deselect after 5 bits, then a full word 0x81
    sel();
    spi_word(8'hFF, 5, 1'b0, mrx);
    desel();
    chk("t4_rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("t4_miso_oe",  32'(miso_oe),      32'h0);
    chk("t4_miso",     32'(miso),         32'h0);
    chk("t4_busy",     32'(bus.busy),     32'h0);
    sel();
    spi_word(8'h81, 8, 1'b0, mrx);
    desel();
    chk("t4_rx_data",  32'(bus.rx_data),  32'h81);
    chk("t4_rx_valid", 32'(bus.rx_valid), 32'h1);
    rx_ack_pulse();

    // Empty TX buffer at LOAD sends zeros; reset mid-transfer
    sel();
    chk("t5_miso_first", 32'(miso), 32'h0);
    spi_word(8'h5A, 8, 1'b0, mrx);
    desel();
    chk("t5_miso_zero", 32'(mrx),         32'h00);
    chk("t5_rx_data",   32'(bus.rx_data), 32'h5A);
    sel();
    tx_write(8'hEE);
    spi_word(8'hFF, 3, 1'b0, mrx);
    PRESETn = 1'b0;
    clks(2);
    chk_reset_values("t5_rst");
    sclk_in = cpol;
    ss_n    = 1'b1;
    mosi    = 1'b0;
    clks(2);
    PRESETn = 1'b1;
    clks(4);

`ifdef SPI_SLAVE_LSBFE_EN
    // LSB first: master 0x01, slave 0x80
    lsbfe = 1'b1;
    clks(2);
    tx_write(8'h80);
    sel();
    spi_word(8'h01, 8, 1'b1, mrx);
    desel();
    chk("t6_rx_data", 32'(bus.rx_data), 32'h01);
    chk("t6_miso",    32'(mrx),         32'h80);
    rx_ack_pulse();
    lsbfe = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
